// File: rtl/switch_pkg.sv
// Shared width helpers and the short debounce default used for simulation builds
// of the multi-channel switch event counter.
package switch_pkg;

  localparam int DEBOUNCE_SIM = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

  // Debounce counter width: ceil(log2(cycles)), never below 1 bit.
  function automatic int dbc_w(input int cycles);
    return (cycles > 2) ? clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: 2-FF synchroniser, stability debounce and rising-edge detect.
// rise_now flags the edge on which stable will go 0->1, so the parent can count on that same edge.
module switch_debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sw_raw,
  output logic stable,
  output logic rise,
  output logic rise_now
);

  localparam int CNT_W = dbc_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_p0;
  logic sync_p1;
  logic [CNT_W-1:0] dbc_cnt;
  logic toggle;

  assign toggle   = (sync_p1 != stable) && (dbc_cnt == CNT_LAST);
  assign rise_now = toggle && !stable;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dbc_cnt <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
    end else begin
      // sync stage p0 -> p1, then debounce on the p1 level
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
      rise    <= rise_now;
      if (sync_p1 == stable) begin
        dbc_cnt <= '0;
      end else if (toggle) begin
        stable  <= ~stable;
        dbc_cnt <= '0;
      end else begin
        dbc_cnt <= dbc_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_switch_event_counter.sv
// N-channel debounced switch event counter with per-channel clear, sticky limit
// flags and a registered channel-select output for the display FSM.
module multi_switch_event_counter
  import switch_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit SATURATE        = 1'b0,
  localparam int SEL_W          = sel_w(N_CH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  sw_in,
  input  logic             count_up,
  input  logic [N_CH-1:0]  clear,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  sw_stable,
  output logic [N_CH-1:0]  rise_pulse,
  output logic [N_CH-1:0]  limit_flag,
  output logic [WIDTH-1:0] sel_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count [N_CH];
  logic [N_CH-1:0]  rise_now;
  logic [WIDTH-1:0] sel_mux;

  function automatic logic at_limit(input logic [WIDTH-1:0] c, input logic up);
    return up ? (c == CNT_MAX) : (c == '0);
  endfunction

  // Natural modular arithmetic gives the wrap; saturation just holds at the limit.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c, input logic up);
    if (SATURATE && at_limit(c, up)) return c;
    return up ? c + WIDTH'(1) : c - WIDTH'(1);
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    switch_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .sw_raw   (sw_in[i]),
      .stable   (sw_stable[i]),
      .rise     (rise_pulse[i]),
      .rise_now (rise_now[i])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == sel) sel_mux = count[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) count[i] <= '0;
      limit_flag <= '0;
      sel_count  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clear[i]) begin
          count[i]      <= '0;
          limit_flag[i] <= 1'b0;
        end else if (rise_now[i]) begin
          count[i] <= step_count(count[i], count_up);
          if (at_limit(count[i], count_up)) limit_flag[i] <= 1'b1;
        end
      end
      sel_count <= sel_mux;
    end
  end

endmodule
